// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Opcode map, FSM encoding and result bundle.
package alu_pkg;

  localparam int OP_W   = 3;
  localparam int DATA_W = 8;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_MAX = 3'd2;
  localparam logic [OP_W-1:0] OP_MIN = 3'd3;
  localparam logic [OP_W-1:0] OP_SHR = 3'd4;
  localparam logic [OP_W-1:0] OP_SHL = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] z;
    logic              of;
    logic [OP_W-1:0]   op;
    logic              ill;
  } res_t;

  function automatic logic is_legal_op(
    input logic [OP_W-1:0] op
  );
    return op <= OP_SHL;
  endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 8-bit signed ALU.
// Used by the sequencer when ALU_SELF_CHECK_EN is defined.
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] z,
  output logic              of
);

  always_comb begin
    z  = '0;
    of = 1'b0;
    unique case (op)
      OP_ADD: begin
        z  = a + b;
        of = (a[7] == b[7]) && (z[7] != a[7]);
      end
      OP_SUB: begin
        z  = a - b;
        of = (a[7] != b[7]) && (z[7] != a[7]);
      end
      OP_MAX: z = ($signed(a) > $signed(b)) ? a : b;
      OP_MIN: z = ($signed(a) < $signed(b)) ? a : b;
      OP_SHR: z = {a[7], a[7:1]};
      OP_SHL: begin
        z  = {b[6:0], 1'b0};
        of = b[7] ^ b[6];
      end
      default: begin
        z  = '0;
        of = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for the 8-bit ALU: command in, settle, result out.
// Optional ALU_SELF_CHECK_EN adds a golden model and mismatch_sticky.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_z,
  input  logic              alu_of,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_z,
  output logic              res_of,
  output logic [OP_W-1:0]   res_op,
  output logic              res_illegal,
  output logic [CNT_W-1:0]  cmd_count,
  output logic [CNT_W-1:0]  of_count,
`ifdef ALU_SELF_CHECK_EN
  output logic              mismatch_sticky,
`endif
  output logic              err_sticky
);

  localparam int SC_W = 4;

  state_t          state, state_nx;
  logic [SC_W-1:0] cnt;
  logic            acc;
  logic            cap;
  logic            legal;
  res_t            res_q;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  assign legal       = is_legal_op(cmd_op);
  assign res_valid   = (state == HOLD);
  assign res_z       = res_q.z;
  assign res_of      = res_q.of;
  assign res_op      = res_q.op;
  assign res_illegal = res_q.ill;

  always_comb begin
    state_nx = state;
    acc      = 1'b0;
    cap      = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          acc      = 1'b1;
          state_nx = legal ? WAIT : HOLD;
        end
      end
      WAIT: begin
        if (cnt == SC_W'(1)) begin
          cap      = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // cmd_ready is registered so it rises one edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      res_q      <= '0;
      cmd_count  <= '0;
      of_count   <= '0;
      err_sticky <= 1'b0;
    end else begin
      state     <= state_nx;
      cmd_ready <= (state_nx == IDLE);
      if (acc) cmd_count <= sat_inc(cmd_count);
      if (acc && legal) begin
        alu_a  <= cmd_a;
        alu_b  <= cmd_b;
        alu_op <= cmd_op;
        cnt    <= SC_W'(SETTLE_CYC);
      end
      if (acc && !legal) begin
        res_q      <= '{z: '0, of: 1'b0,
                        op: cmd_op, ill: 1'b1};
        err_sticky <= 1'b1;
      end
      if (state == WAIT && !cap) cnt <= cnt - 1'b1;
      if (cap) begin
        res_q <= '{z: alu_z, of: alu_of,
                   op: alu_op, ill: 1'b0};
        if (alu_of) of_count <= sat_inc(of_count);
      end
    end
  end

`ifdef ALU_SELF_CHECK_EN
  logic [DATA_W-1:0] ref_z;
  logic              ref_of;

  alu_ref_model u_ref (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .z  (ref_z),
    .of (ref_of)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_sticky <= 1'b0;
    end else if (cap) begin
      if (ref_z != alu_z || ref_of != alu_of)
        mismatch_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer.
// Plays the ALU and the command/result endpoints.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int S   = 1;
  localparam int CW  = 5;
  localparam int SAT = 31;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [7:0]    cmd_a = '0;
  logic [7:0]    cmd_b = '0;
  logic [2:0]    cmd_op = '0;
  logic [7:0]    alu_a, alu_b;
  logic [2:0]    alu_op;
  logic [7:0]    alu_z;
  logic          alu_of;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [7:0]    res_z;
  logic          res_of;
  logic [2:0]    res_op;
  logic          res_illegal;
  logic [CW-1:0] cmd_count, of_count;
  logic          err_sticky;
  logic          mm;
  logic [7:0]    ref_z;
  logic          ref_of;

  alu_cmd_sequencer #(
    .SETTLE_CYC (S),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_op      (cmd_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_z       (alu_z),
    .alu_of      (alu_of),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_z       (res_z),
    .res_of      (res_of),
    .res_op      (res_op),
    .res_illegal (res_illegal),
    .cmd_count   (cmd_count),
    .of_count    (of_count),
`ifdef ALU_SELF_CHECK_EN
    .mismatch_sticky (mm),
`endif
    .err_sticky  (err_sticky)
  );

`ifndef ALU_SELF_CHECK_EN
  assign mm = 1'b0;
`endif

  alu_ref_model u_ref (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .z  (ref_z),
    .of (ref_of)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [7:0] z;
    logic       of;
  } zo_t;

  // Integer-arithmetic ALU behaviour
  function automatic zo_t alu_model(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [2:0] op
  );
    int sa, sb, r;
    zo_t o;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd0: r = sa + sb;
      3'd1: r = sa - sb;
      3'd2: r = (sa > sb) ? sa : sb;
      3'd3: r = (sa < sb) ? sa : sb;
      3'd4: r = (sa - (sa & 1)) / 2;
      3'd5: r = sb * 2;
      default: r = 0;
    endcase
    o.z  = 8'(r);
    o.of = (op <= 3'd1 || op == 3'd5)
           && (r > 127 || r < -128);
    return o;
  endfunction

  logic faulty = 1'b0;
  zo_t  alu_out;

  always_comb begin
    alu_out = alu_model(alu_a, alu_b, alu_op);
    if (faulty && alu_op == OP_SHL) alu_out = '0;
    alu_z  = alu_out.z;
    alu_of = alu_out.of;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  function automatic int sat(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  int         exp_cmd = 0;
  int         exp_ofc = 0;
  logic       exp_err = 1'b0;
  logic [7:0] last_a = '0;
  logic [7:0] last_b = '0;
  logic [2:0] last_op = '0;
  logic [7:0] pend_a, pend_b;
  logic [2:0] pend_op;

  task automatic note_accept(input logic [7:0] a,
                             input logic [7:0] b,
                             input logic [2:0] op);
    exp_cmd = sat(exp_cmd);
    pend_a  = a;
    pend_b  = b;
    pend_op = op;
    if (op <= 3'd5) begin
      last_a  = a;
      last_b  = b;
      last_op = op;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] a,
                      input logic [7:0] b,
                      input logic [2:0] op);
    int i;
    @(negedge clk);
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_valid = 1'b1;
    i = 0;
    while (!cmd_ready && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (!cmd_ready) begin
      tmo("accept");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_a     = 8'($urandom);
    cmd_b     = 8'($urandom);
    cmd_op    = 3'($urandom);
    note_accept(a, b, op);
    chk("cmd_count", 32'(cmd_count), 32'(exp_cmd));
    chk("alu_a", 32'(alu_a), 32'(last_a));
    chk("alu_b", 32'(alu_b), 32'(last_b));
    chk("alu_op", 32'(alu_op), 32'(last_op));
  endtask

  task automatic recv(input int dly,
                      output logic [7:0] oz,
                      output logic oof,
                      output logic oill);
    zo_t  e;
    int   lat;
    logic ill;
    oz   = '0;
    oof  = 1'b0;
    oill = 1'b0;
    ill  = (pend_op > 3'd5);
    if (ill) e = '0;
    else e = alu_model(pend_a, pend_b, pend_op);
    if (faulty && pend_op == OP_SHL) e = '0;
    lat = 0;
    while (!res_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!res_valid) begin
      tmo("result");
      return;
    end
    if (!ill && e.of) exp_ofc = sat(exp_ofc);
    chk("latency", 32'(lat), ill ? 32'd0 : 32'(S));
    chk("res_z", 32'(res_z), 32'(e.z));
    chk("res_of", 32'(res_of), 32'(e.of));
    chk("res_op", 32'(res_op), 32'(pend_op));
    chk("res_ill", 32'(res_illegal), 32'(ill));
    chk("of_count", 32'(of_count), 32'(exp_ofc));
    chk("err", 32'(err_sticky), 32'(exp_err));
    chk("rdy_hold", 32'(cmd_ready), 32'd0);
    chk("alu_op_h", 32'(alu_op), 32'(last_op));
    if (!ill && !faulty) begin
      chk("ref_z", 32'(ref_z), 32'(e.z));
      chk("ref_of", 32'(ref_of), 32'(e.of));
    end
    oz   = res_z;
    oof  = res_of;
    oill = res_illegal;
    repeat (dly) begin
      @(posedge clk);
      #1;
      chk("stall_v", 32'(res_valid), 32'd1);
      chk("stall_z", 32'(res_z), 32'(e.z));
      chk("stall_rdy", 32'(cmd_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("post_v", 32'(res_valid), 32'd0);
    chk("post_rdy", 32'(cmd_ready), 32'd1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    int         dly;
    logic [7:0] z;
    logic       of;
    logic       ill;
  } vec_t;

  vec_t tv[12];

  task automatic chk_zero(input string nm);
    chk({nm, "_rdy"}, 32'(cmd_ready), 32'd0);
    chk({nm, "_v"}, 32'(res_valid), 32'd0);
    chk({nm, "_a"}, 32'(alu_a), 32'd0);
    chk({nm, "_b"}, 32'(alu_b), 32'd0);
    chk({nm, "_op"}, 32'(alu_op), 32'd0);
    chk({nm, "_z"}, 32'(res_z), 32'd0);
    chk({nm, "_of"}, 32'(res_of), 32'd0);
    chk({nm, "_rop"}, 32'(res_op), 32'd0);
    chk({nm, "_ill"}, 32'(res_illegal), 32'd0);
    chk({nm, "_cc"}, 32'(cmd_count), 32'd0);
    chk({nm, "_oc"}, 32'(of_count), 32'd0);
    chk({nm, "_err"}, 32'(err_sticky), 32'd0);
    chk({nm, "_mm"}, 32'(mm), 32'd0);
  endtask

  initial begin
    logic [7:0] z;
    logic       of, ill;
    int         t0, t1, n;
    zo_t        e;

    tv[0]  = '{8'h40, 8'h40, 3'd0, 0, 8'h80, 1'b1, 1'b0};
    tv[1]  = '{8'h0F, 8'hE4, 3'd2, 5, 8'h0F, 1'b0, 1'b0};
    tv[2]  = '{8'h64, 8'hFF, 3'd3, 0, 8'hFF, 1'b0, 1'b0};
    tv[3]  = '{8'h07, 8'h03, 3'd6, 0, 8'h00, 1'b0, 1'b1};
    tv[4]  = '{8'hFB, 8'h00, 3'd4, 0, 8'hFD, 1'b0, 1'b0};
    tv[5]  = '{8'h00, 8'hF8, 3'd5, 1, 8'hF0, 1'b0, 1'b0};
    tv[6]  = '{8'h80, 8'h01, 3'd1, 0, 8'h7F, 1'b1, 1'b0};
    tv[7]  = '{8'h03, 8'h05, 3'd7, 2, 8'h00, 1'b0, 1'b1};
    tv[8]  = '{8'h00, 8'h40, 3'd5, 0, 8'h80, 1'b1, 1'b0};
    tv[9]  = '{8'h7F, 8'h7F, 3'd2, 0, 8'h7F, 1'b0, 1'b0};
    tv[10] = '{8'hC4, 8'hB5, 3'd0, 0, 8'h79, 1'b1, 1'b0};
    tv[11] = '{8'h64, 8'hCE, 3'd1, 0, 8'h96, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rdy_pre", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rdy_rise", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      send(tv[i].a, tv[i].b, tv[i].op);
      recv(tv[i].dly, z, of, ill);
      chk($sformatf("tv%0d_z", i), 32'(z), 32'(tv[i].z));
      chk($sformatf("tv%0d_of", i), 32'(of), 32'(tv[i].of));
      chk($sformatf("tv%0d_ill", i), 32'(ill), 32'(tv[i].ill));
    end

    // Back-to-back with res_ready held high
    @(negedge clk);
    res_ready = 1'b1;
    cmd_a     = 8'hC4;
    cmd_b     = 8'hB5;
    cmd_op    = OP_ADD;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    note_accept(8'hC4, 8'hB5, OP_ADD);
    exp_ofc = sat(exp_ofc);
    cmd_a  = 8'h64;
    cmd_b  = 8'hCE;
    cmd_op = OP_SUB;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 20) begin
      chk("b2b_rdy", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    chk("b2b_z1", 32'(res_z), 32'h79);
    chk("b2b_of1", 32'(res_of), 32'd1);
    chk("b2b_rdy2", 32'(cmd_ready), 32'd0);
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    t1 = cyc;
    cmd_valid = 1'b0;
    note_accept(8'h64, 8'hCE, OP_SUB);
    exp_ofc = sat(exp_ofc);
    chk("b2b_gap", 32'(t1 - t0), 32'(S + 2));
    n = 0;
    while (!res_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_z2", 32'(res_z), 32'h96);
    chk("b2b_of2", 32'(res_of), 32'd1);
    chk("b2b_oc", 32'(of_count), 32'(exp_ofc));
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("b2b_done", 32'(res_valid), 32'd0);

    // Random commands against the model
    for (int i = 0; i < 120; i++) begin
      send(8'($urandom), 8'($urandom),
           3'($urandom_range(0, 7)));
      recv(int'($urandom_range(0, 3)), z, of, ill);
    end

    // Drive the overflow counter into saturation
    for (int i = 0; i < 35; i++) begin
      send(8'h40, 8'h40, OP_ADD);
      recv(0, z, of, ill);
    end
    chk("sat_cc", 32'(cmd_count), 32'(SAT));
    chk("sat_oc", 32'(of_count), 32'(SAT));

    // Reset during WAIT
    send(8'd10, 8'd20, OP_ADD);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("mid");
    exp_cmd = 0;
    exp_ofc = 0;
    exp_err = 1'b0;
    last_a  = '0;
    last_b  = '0;
    last_op = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("mid_nov", 32'(res_valid), 32'd0);
    end
    send(8'd1, 8'd2, OP_ADD);
    recv(0, z, of, ill);
    chk("mid_z", 32'(z), 32'd3);
    chk("mid_cc", 32'(cmd_count), 32'd1);

`ifdef ALU_SELF_CHECK_EN
    faulty = 1'b1;
    send(8'hFB, 8'h00, OP_SHR);
    recv(0, z, of, ill);
    chk("sc_shr", 32'(z), 32'hFD);
    chk("sc_mm0", 32'(mm), 32'd0);
    send(8'h00, 8'hF8, OP_SHL);
    recv(0, z, of, ill);
    chk("sc_mm1", 32'(mm), 32'd1);
    faulty = 1'b0;
`endif

    e = alu_model(8'h40, 8'h40, OP_ADD);
    chk("model_self", 32'(e.z), 32'h80);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
